// File: rtl/timer_peripheral_if.sv
// ============================================================================
// timer_peripheral_if : MEM-stage bus bundle between CPU and the timer block.
// Revision 1.0
// ============================================================================
`default_nettype none

interface timer_peripheral_if;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic        hit;
    logic        irq;

    modport master (
        output Address, Write_data, MemRead, MemWrite,
        input  Read_data, hit, irq
    );

    modport slave (
        input  Address, Write_data, MemRead, MemWrite,
        output Read_data, hit, irq
    );
endinterface

`default_nettype wire

// File: rtl/timer_peripheral.sv
// ============================================================================
// timer_peripheral : memory-mapped prescaled interval timer with level irq and
// optional free-running SYSTICK counter (enabled by macro TIMER_SYSTICK_EN).
// Revision 1.0
// ============================================================================
`default_nettype none

module timer_peripheral #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    timer_peripheral_if.slave bus
);

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;
    localparam logic [15:0] PCNT_LAST    = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] rdata;

    logic sel_th, sel_tl, sel_tcon, sel_sys;
    logic wr_th, wr_tl, wr_tcon;
    logic tick, ovf;

    assign sel_th   = (bus.Address == ADDR_TH);
    assign sel_tl   = (bus.Address == ADDR_TL);
    assign sel_tcon = (bus.Address == ADDR_TCON);

    assign wr_th   = bus.MemWrite && sel_th;
    assign wr_tl   = bus.MemWrite && sel_tl;
    assign wr_tcon = bus.MemWrite && sel_tcon;

    assign tick = tcon_q[0] && (pcnt_q == PCNT_LAST);
    assign ovf  = tick && (tl_q == 32'hFFFF_FFFF);

`ifdef TIMER_SYSTICK_EN
    logic [31:0] systick_q, systick_d;

    assign sel_sys   = (bus.Address == ADDR_SYSTICK);
    assign systick_d = systick_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_d;
        end
    end
`else
    assign sel_sys = 1'b0;
`endif

    always_comb begin
        pcnt_d = pcnt_q + 16'd1;
        // Disabling via TCON write zeroes the prescaler on the same edge.
        if (!tcon_q[0] || (wr_tcon && !bus.Write_data[0]) || tick) begin
            pcnt_d = '0;
        end

        th_d = wr_th ? bus.Write_data : th_q;

        tl_d = tl_q;
        if (wr_tl) begin
            tl_d = bus.Write_data;
        end else if (ovf) begin
            tl_d = th_q;
        end else if (tick) begin
            tl_d = tl_q + 32'd1;
        end

        tcon_d = tcon_q;
        if (wr_tcon) begin
            tcon_d = bus.Write_data[2:0];
        end else if (ovf && tcon_q[1]) begin
            tcon_d[2] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            pcnt_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            pcnt_q <= pcnt_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_th) begin
            rdata = th_q;
        end else if (sel_tl) begin
            rdata = tl_q;
        end else if (sel_tcon) begin
            rdata = {29'd0, tcon_q};
        end
`ifdef TIMER_SYSTICK_EN
        else if (sel_sys) begin
            rdata = systick_q;
        end
`endif
    end

    assign bus.hit       = sel_th || sel_tl || sel_tcon || sel_sys;
    assign bus.Read_data = bus.MemRead ? rdata : 32'd0;
    assign bus.irq       = tcon_q[1] && tcon_q[2];

endmodule

`default_nettype wire

// File: doc/timer_peripheral.md
# timer_peripheral

Memory-mapped interval timer with interrupt and free-running system tick counter. Sits beside the data memory on the CPU's MEM-stage bus, decoding 0x40000000–0x40000008 and 0x40000014 (the data memory keeps 0x4000000C LED and 0x40000010 digit). It returns read data plus a hit flag so the top level can mux it against data-memory read data. It drives a level interrupt request to the pipeline's exception logic.

## Interface
- PRESCALE, 1: core clock cycles per timer tick; legal range 1..65535.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset: sampled on rising clk edge, state cleared when reset==0.
- Address  input  32  byte address from MEM stage.
- Write_data  input  32  store data.
- MemRead  input  1  load strobe.
- MemWrite  input  1  store strobe.
- Read_data  output  32  read data; 0 when not selected.
- hit  output  1  high when Address matches any register here (independent of MemRead/MemWrite).
- irq  output  1  interrupt request, level.

## Operation
- Registers:
  - TH (0x40000000): reload value, R/W.
  - TL (0x40000004): counter, R/W.
  - TCON (0x40000008): bits [2:0], upper bits read 0. bit0 = enable, bit1 = irq_en, bit2 = irq_status. Bit2 is set by hardware and cleared only by a write of 0 to it.
  - SYSTICK (0x40000014): R/O; writes ignored.
- Decode is full 32-bit compare. Other addresses: hit=0, Read_data=0, no state change.
- Prescaler: 16-bit counter `pcnt`. While TCON[0]=1 it counts 0..PRESCALE-1 and wraps. `tick` is asserted when pcnt==PRESCALE-1; with PRESCALE=1, tick is asserted every cycle. When TCON[0]=0, pcnt is held at 0.
- On tick:
  - if TL==32'hFFFFFFFF: TL<=TH (overflow event), and TCON[2]<=1 if TCON[1]=1.
  - else TL<=TL+1.
- irq = TCON[1] & TCON[2], from registered state.
- SYSTICK increments by 1 every clk cycle (not prescaled, not gated by enable). It wraps 32'hFFFFFFFF→0.
- Simultaneous events in the same cycle:
  - Write to TL with a tick: write wins.
  - Write to TH with an overflow: TL loads the old TH; TH takes the new value.
  - Write to TCON with an overflow: the written value wins entirely, including bit2.
  - Write to TCON clearing bit0: pcnt is zeroed on the same edge.
- Reset (reset==0 at an edge, including mid-count): TH, TL, TCON, pcnt and SYSTICK all become 0. Reset overrides any simultaneous write.

## Timing
- Reads are combinational: Read_data is valid in the same cycle as Address/MemRead, matching data-memory read timing.
- Writes take effect at the rising edge where MemWrite=1. The new value is readable the next cycle.
- Overflow to irq latency:
  - Edge N performs the reload and sets TCON[2].
  - irq is high from just after edge N.
  - irq stays high until a TCON write clears bit2 or bit1.
- Reset values: Read_data=0 (combinational, follows MemRead/Address), hit per Address, irq=0.
- Overflow period = (2^32 − TH) × PRESCALE cycles after the first reload.

## Configuration
- TIMER_SYSTICK_EN:
  - Defined: the SYSTICK register is implemented as above, and 0x40000014 asserts hit.
  - Undefined: there is no SYSTICK flop. 0x40000014 is not decoded (hit=0, Read_data=0), so the top-level mux returns data-memory output for that address.

## Test plan
- Reset value check: hold reset=0 two cycles, release. Read each address → TH=0, TL=0, TCON=0, SYSTICK=1 on the first cycle after release; irq=0.
- Basic overflow, PRESCALE=1:
  - Stimulus: write TH=32'hFFFFFFFC, TL=32'hFFFFFFFC, TCON=3'b011.
  - Required: TL reads FFFFFFFD, FFFFFFFE, FFFFFFFF, then FFFFFFFC.
  - irq rises one cycle after TL=FFFFFFFF.
  - TCON reads 3'b111.
  - Write TCON=3'b011 → irq low the next cycle.
- Prescale, PRESCALE=4: TCON=1, TL=0 → TL==1 after 4 cycles and TL==5 after 20 cycles. Writing TCON=0 freezes TL; re-enabling restarts a full 4-cycle prescale.
- Collisions:
  - Write TL=32'h10 on the overflow cycle → TL reads 10, not TH.
  - Write TH=32'h55 on the overflow cycle → TL reads the old TH; TH reads 55.
  - Write TCON=3'b001 on the overflow cycle → bit2 stays 0 and irq stays 0.
- Reset mid-operation: reset=0 while TL=32'h1234 and irq=1 → after that edge TL=0, TCON=0, irq=0, even if MemWrite to TL is asserted the same cycle.
- Decode/config:
  - Read 0x4000000C → hit=0, Read_data=0.
  - With TIMER_SYSTICK_EN, two reads of 0x40000014 taken 10 cycles apart differ by 10.
  - Without it, the same reads give hit=0, Read_data=0.
